// File: rtl/cplx_fix_op_if.sv
// Start/op/ready handshake and operand/result bus between the FFT controller
// and the fixed-point complex arithmetic responder.
interface cplx_fix_op_if #(
  parameter int W = 32
);
  logic         start;
  logic         op;
  logic [W-1:0] re1;
  logic [W-1:0] im1;
  logic [W-1:0] re2;
  logic [W-1:0] im2;
  logic [W-1:0] re;
  logic [W-1:0] im;
  logic         ready;
  logic         busy;
  logic         ovf;

  modport master (
    output start, op, re1, im1, re2, im2,
    input  re, im, ready, busy, ovf
  );

  modport slave (
    input  start, op, re1, im1, re2, im2,
    output re, im, ready, busy, ovf
  );
endinterface

// File: rtl/cplx_fix_op.sv
// Fixed-point complex add (1 cycle) / multiply (4 products on one shared
// signed multiplier, then round and clamp) with a start/ready handshake.
module cplx_fix_op #(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int SAT  = 1
) (
  input logic          clk,
  input logic          rst,
  cplx_fix_op_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_MUL   = 3'd2,
    S_FIN   = 3'd3,
    S_DONE  = 3'd4,
    S_REARM = 3'd5
  } state_t;

  localparam logic signed [2*W:0] RND = {{(2*W){1'b0}}, 1'b1} << (FRAC-1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic signed [W-1:0]    r_a, r_b, r_c, r_d;
  logic signed [2*W:0]    r_acc_r, r_acc_i;
  logic [1:0]             r_k;
  logic [W-1:0]           r_re, r_im;
  logic                   r_ovf, r_ready, r_busy;

  logic signed [W-1:0]    w_mul_x, w_mul_y;
  logic signed [2*W-1:0]  w_prod;
  logic signed [2*W:0]    w_prod_x;
  logic signed [W:0]      w_sum_re, w_sum_im;
  logic signed [2*W:0]    w_rnd_re, w_rnd_im;
  logic [W:0]             w_add_re, w_add_im, w_fin_re, w_fin_im;

  // In range iff the bits above the result sign all copy it; returns {ovf, value}.
  function automatic logic [W:0] clamp_w(input logic signed [2*W:0] v);
    logic         in_rng;
    logic [W-1:0] res;
    in_rng = (v[2*W:W-1] == {(W+2){v[2*W]}});
    if (in_rng) begin
      res = v[W-1:0];
    end else if (SAT != 0) begin
      res = v[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      res = v[W-1:0];
    end
    return {~in_rng, res};
  endfunction

  // Shared multiplier operand select: k0 a*c, k1 b*d, k2 a*d, k3 b*c.
  always_comb begin
    w_mul_x = r_a;
    w_mul_y = r_c;
    case (r_k)
      2'd0: begin w_mul_x = r_a; w_mul_y = r_c; end
      2'd1: begin w_mul_x = r_b; w_mul_y = r_d; end
      2'd2: begin w_mul_x = r_a; w_mul_y = r_d; end
      2'd3: begin w_mul_x = r_b; w_mul_y = r_c; end
      default: begin w_mul_x = r_a; w_mul_y = r_c; end
    endcase
  end

  assign w_prod   = w_mul_x * w_mul_y;
  assign w_prod_x = {w_prod[2*W-1], w_prod};
  assign w_sum_re = {r_a[W-1], r_a} + {r_c[W-1], r_c};
  assign w_sum_im = {r_b[W-1], r_b} + {r_d[W-1], r_d};
  assign w_rnd_re = (r_acc_r + RND) >>> FRAC;
  assign w_rnd_im = (r_acc_i + RND) >>> FRAC;
  assign w_add_re = clamp_w({{W{w_sum_re[W]}}, w_sum_re});
  assign w_add_im = clamp_w({{W{w_sum_im[W]}}, w_sum_im});
  assign w_fin_re = clamp_w(w_rnd_re);
  assign w_fin_im = clamp_w(w_rnd_im);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; REARM holds off a start that is still asserted after ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = bus.op ? S_ADD : S_MUL;
               else           w_state_nxt = S_IDLE;
      S_ADD:   w_state_nxt = S_DONE;
      S_MUL:   if (r_k == 2'd3) w_state_nxt = S_FIN;
               else             w_state_nxt = S_MUL;
      S_FIN:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_REARM;
      S_REARM: if (bus.start) w_state_nxt = S_REARM;
               else           w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, product accumulation and registered results/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_c <= '0; r_d <= '0;
      r_acc_r <= '0; r_acc_i <= '0; r_k <= 2'd0;
      r_re <= '0; r_im <= '0; r_ovf <= 1'b0;
      r_ready <= 1'b0; r_busy <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt == S_ADD) || (w_state_nxt == S_MUL) || (w_state_nxt == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a <= bus.re1; r_b <= bus.im1; r_c <= bus.re2; r_d <= bus.im2;
          end
          r_k <= 2'd0;
        end
        S_ADD: begin
          r_re  <= w_add_re[W-1:0];
          r_im  <= w_add_im[W-1:0];
          r_ovf <= w_add_re[W] | w_add_im[W];
        end
        S_MUL: begin
          case (r_k)
            2'd0:    r_acc_r <= w_prod_x;
            2'd1:    r_acc_r <= r_acc_r - w_prod_x;
            2'd2:    r_acc_i <= w_prod_x;
            2'd3:    r_acc_i <= r_acc_i + w_prod_x;
            default: r_acc_r <= r_acc_r;
          endcase
          r_k <= r_k + 2'd1;
        end
        S_FIN: begin
          r_re  <= w_fin_re[W-1:0];
          r_im  <= w_fin_im[W-1:0];
          r_ovf <= w_fin_re[W] | w_fin_im[W];
        end
        default: r_k <= r_k;
      endcase
    end
  end

  assign bus.re    = r_re;
  assign bus.im    = r_im;
  assign bus.ovf   = r_ovf;
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_cplx_fix_op.sv
// Directed bench for cplx_fix_op: add/multiply results, latency, saturation,
// handshake re-arm and reset abort.
module tb_cplx_fix_op;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cplx_fix_op_if #(.W(W)) bus ();

  cplx_fix_op #(.W(W), .FRAC(16), .SAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation; operands are scrambled after the accept edge and start is
  // held for `hold` cycles past ready before being dropped.
  task automatic run_op(input string tag, input logic op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] er,
                        input logic [31:0] ei, input logic eo, input int hold);
    int cyc;
    int pulses;
    bus.start = 1'b1; bus.op = op;
    bus.re1 = a; bus.im1 = b; bus.re2 = c; bus.im2 = d;
    @(posedge clk); #1;
    cyc = 1;
    bus.op = ~op; bus.re1 = ~a; bus.im1 = ~b; bus.re2 = ~c; bus.im2 = ~d;
    while (!bus.ready && cyc < 20) begin
      chk({tag, ".busy"}, {63'd0, bus.busy}, 64'd1);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, ".re"}, {32'd0, bus.re}, {32'd0, er});
    chk({tag, ".im"}, {32'd0, bus.im}, {32'd0, ei});
    chk({tag, ".ovf"}, {63'd0, bus.ovf}, {63'd0, eo});
    chk({tag, ".busy_at_ready"}, {63'd0, bus.busy}, 64'd0);
    pulses = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.ready) pulses++;
      chk({tag, ".hold_re"}, {32'd0, bus.re}, {32'd0, er});
      chk({tag, ".hold_im"}, {32'd0, bus.im}, {32'd0, ei});
    end
    if (hold > 0) chk({tag, ".extra_ready"}, 64'(pulses), 64'd0);
    bus.start = 1'b0;
    repeat (hold > 0 ? 1 : 2) @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    // Start raised together with reset: must not be accepted.
    rst = 1'b1;
    bus.start = 1'b1; bus.op = 1'b0;
    bus.re1 = 32'h0001_0000; bus.im1 = 32'h0002_0000;
    bus.re2 = 32'h0003_0000; bus.im2 = 32'h0004_0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; bus.start = 1'b0;
    chk("rst.re", {32'd0, bus.re}, 64'd0);
    chk("rst.im", {32'd0, bus.im}, 64'd0);
    chk("rst.ready", {63'd0, bus.ready}, 64'd0);
    chk("rst.busy", {63'd0, bus.busy}, 64'd0);
    chk("rst.ovf", {63'd0, bus.ovf}, 64'd0);
    @(posedge clk); #1;
    chk("rst.no_accept", {63'd0, bus.busy}, 64'd0);

    run_op("add", 1'b1, 32'h0001_8000, 32'hFFFE_0000, 32'h0000_4000, 32'h0000_8000,
           2, 32'h0001_C000, 32'hFFFE_8000, 1'b0, 0);
    run_op("mul", 1'b0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
           6, 32'hFFFB_0000, 32'h000A_0000, 1'b0, 0);
    run_op("twiddle", 1'b0, 32'h0000_8000, 32'h0000_4000, 32'h0000_0000, 32'hFFFF_0000,
           6, 32'h0000_4000, 32'hFFFF_8000, 1'b0, 0);
    run_op("round", 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_8000, 32'h0000_0000,
           6, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);
    run_op("sat_add", 1'b1, 32'h7FFF_0000, 32'h0000_0000, 32'h0002_0000, 32'h0000_0000,
           2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0);
    run_op("sat_mul", 1'b0, 32'h0100_0000, 32'h0000_0000, 32'h0100_0000, 32'h0000_0000,
           6, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0);
    // In-range op clears ovf; start held 5 cycles past ready, then 1-cycle gap.
    run_op("hold_mul", 1'b0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
           6, 32'hFFFB_0000, 32'h000A_0000, 1'b0, 5);
    run_op("rearm_add", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000,
           2, 32'h0003_0000, 32'hFFFE_0000, 1'b0, 0);

    // Reset during product k=2 aborts the multiply.
    bus.start = 1'b1; bus.op = 1'b0;
    bus.re1 = 32'h0001_0000; bus.im1 = 32'h0002_0000;
    bus.re2 = 32'h0003_0000; bus.im2 = 32'h0004_0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.re", {32'd0, bus.re}, 64'd0);
    chk("abort.im", {32'd0, bus.im}, 64'd0);
    chk("abort.busy", {63'd0, bus.busy}, 64'd0);
    chk("abort.ready", {63'd0, bus.ready}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ready || bus.busy) pulses++;
    end
    chk("abort.quiet", 64'(pulses), 64'd0);
    run_op("post_abort", 1'b0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
           6, 32'hFFFB_0000, 32'h000A_0000, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cplx_fix_op.md
Name: cplx_fix_op

Overview:
- Sequential fixed-point complex arithmetic responder for the fixed-point FFT datapath variant.
- Drop-in for the floating-point complex mult/add unit. It uses the same start/op/ready handshake as seen from the FFT controller.
- Add completes in one cycle. Multiply reuses one signed 32x32 multiplier over four cycles.
- Sits between the FFT control FSM and the twiddle/RAM operand registers.

Parameters:
W, 32, operand/result width (two's complement).
FRAC, 16, fraction bits (Q16.16 at defaults; 1.0 = 0x00010000).
SAT, 1, 1 = saturate results on overflow; 0 = wrap.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request; held high by the initiator until ready is seen
op  in  1  1 = complex add, 0 = complex multiply
re1  in  W  operand A real
im1  in  W  operand A imaginary
re2  in  W  operand B real
im2  in  W  operand B imaginary
re  out  W  result real, registered
im  out  W  result imaginary, registered
ready  out  1  one-cycle pulse: result valid
busy  out  1  high from operation accept until ready
ovf  out  1  sticky-per-op: any component saturated/wrapped in the last result

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: re=0, im=0, ready=0, busy=0, ovf=0, FSM=IDLE, product counter=0.
- Reset has priority in every state. Reset mid-operation aborts the operation: no ready pulse, outputs cleared.
- States: IDLE, ADD, MUL, FIN, DONE, REARM.
- IDLE: when start=1, latch re1/im1/re2/im2/op on that edge and set busy=1. Go to ADD if op=1, else MUL. Operands are never re-sampled mid-operation.
- ADD (1 cycle):
  - re = sat(re1+re2), im = sat(im1+im2), computed at W+1 bits.
  - Go to DONE.
  - Add latency: ready high in the 2nd cycle after the accept edge.
- MUL (4 cycles, counter k=0..3), one product per cycle into two 2W+1-bit accumulators:
  - k0: accR = a*c
  - k1: accR -= b*d
  - k2: accI = a*d
  - k3: accI += b*c
  - where a=re1, b=im1, c=re2, d=im2.
  - Then go to FIN.
- FIN (1 cycle):
  - r = (acc + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift).
  - If SAT=1, clamp r to [-2^(W-1), 2^(W-1)-1]; if SAT=0, keep the low W bits.
  - Write re/im; ovf=1 if either component was out of range.
  - Go to DONE.
  - Multiply latency: ready high in the 6th cycle after the accept edge.
- DONE (1 cycle): ready=1, busy=0. Go to REARM.
- REARM:
  - Stay while start=1. A request still held after ready is never treated as a new op.
  - Go to IDLE when start=0.
  - A minimum of one start-low cycle separates operations.
- re/im/ovf hold their value from the ready cycle until the next op's ADD/FIN write. The initiator may read them for any number of cycles.
- Add overflow: ovf uses the same rule (W+1-bit sum outside range).
- Simultaneous start rise and rst: reset wins, nothing is accepted.
- Changing op or operands while busy has no effect.
- ready and busy are never both 1.

Test Plan:
- Reset, then add (1.5-2.0j)+(0.25+0.5j): re1=0x00018000, im1=0xFFFE0000, re2=0x00004000, im2=0x00008000 -> ready 2 cycles after accept; re=0x0001C000, im=0xFFFE8000, ovf=0.
- Multiply (1+2j)(3+4j): 0x00010000, 0x00020000, 0x00030000, 0x00040000 -> ready exactly 6 cycles after accept; re=0xFFFB0000, im=0x000A0000, ovf=0.
- Twiddle multiply (0.5+0.25j)(0-1j): im2=0xFFFF0000 -> re=0x00004000, im=0xFFFF8000. Rounding: re1=0x00000001, re2=0x00008000, others 0 -> re=0x00000001.
- Saturation:
  - Add re1=0x7FFF0000, re2=0x00020000 -> re=0x7FFFFFFF, ovf=1.
  - Multiply re1=re2=0x01000000 -> re=0x7FFFFFFF, ovf=1.
  - Next in-range op clears ovf.
- Handshake: hold start high 5 cycles past ready -> exactly one ready pulse, outputs stable. Drop start for 1 cycle, raise with op=1 -> new result and a single new ready pulse.
- Assert rst in MUL k=2 -> no ready pulse; next cycle re=im=0 and busy=0. A fresh multiply then completes with correct values.
